irrigation_phase_timer: RTL

Tick consumer for the irrigation controller. It counts rising edges of the gated `Ctrl_clk` produced by the frequency selector, tracks which irrigation phase (fill, sprinkler, drip, cleaning) is running, and returns a one-cycle done pulse to the main FSM when that phase has received its programmed number of ticks. It runs entirely in the system clock domain and closes the loop from selector back to FSM.

---
 rtl/irrigation_phase_timer_pkg.sv | 28 ++
 rtl/irrigation_phase_timer_tick_edge_detect.sv | 49 ++++
 rtl/irrigation_phase_timer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/irrigation_phase_timer_pkg.sv
// +----------------------------------------------------------------------+
// | irrigation_pkg                                                       |
// | Shared phase encoding and default tick limits for irrigation blocks.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package irrigation_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_FILL = 3'd1,
    PH_ASP  = 3'd2,
    PH_GOT  = 3'd3,
    PH_LIMP = 3'd4,
    PH_WAIT = 3'd5,
    PH_HALT = 3'd6
  } phase_t;

  localparam int DEF_FILL_TICKS = 8;
  localparam int DEF_ASP_TICKS  = 16;
  localparam int DEF_GOT_TICKS  = 32;
  localparam int DEF_LIMP_TICKS = 4;
  localparam int DEF_CNT_W      = 8;

endpackage

`default_nettype wire

// File: rtl/irrigation_phase_timer_tick_edge_detect.sv
// +----------------------------------------------------------------------+
// | tick_edge_detect                                                     |
// | Rising-edge strobe on Ctrl_clk; TICK_SYNC_EN adds a 2-flop sync.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tick_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic Ctrl_clk,
  output logic tick_pulse
);

`ifdef TICK_SYNC_EN
  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= Ctrl_clk;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign tick_pulse = r_sync2 & ~r_prev;
`else
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= Ctrl_clk;
    end
  end

  assign tick_pulse = Ctrl_clk & ~r_prev;
`endif

endmodule

`default_nettype wire

// File: rtl/irrigation_phase_timer.sv
// +----------------------------------------------------------------------+
// | irrigation_phase_timer                                               |
// | Counts selector ticks per irrigation phase, pulses done on limit.    |
// | Optional macro: TICK_SYNC_EN (synchronize Ctrl_clk).                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module irrigation_phase_timer
  import irrigation_pkg::*;
#(
  parameter int FILL_TICKS = DEF_FILL_TICKS,
  parameter int ASP_TICKS  = DEF_ASP_TICKS,
  parameter int GOT_TICKS  = DEF_GOT_TICKS,
  parameter int LIMP_TICKS = DEF_LIMP_TICKS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Ctrl_clk,
  input  logic             start_fill,
  input  logic             state,
  input  logic             Aspersao,
  input  logic             Gotejamento,
  input  logic             Limpeza,
  input  logic             ERRO,
  output logic             fill_done,
  output logic             asp_done,
  output logic             got_done,
  output logic             limp_done,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] tick_count,
  output logic             busy,
  output logic             err_halt
);

  localparam logic [CNT_W-1:0] c_FILL_LAST = CNT_W'(FILL_TICKS - 1);
  localparam logic [CNT_W-1:0] c_ASP_LAST  = CNT_W'(ASP_TICKS - 1);
  localparam logic [CNT_W-1:0] c_GOT_LAST  = CNT_W'(GOT_TICKS - 1);
  localparam logic [CNT_W-1:0] c_LIMP_LAST = CNT_W'(LIMP_TICKS - 1);

  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_done;      // {limp, got, asp, fill}
  logic [3:0]       w_done_nxt;
  logic             w_tick;
  logic             w_req_fill;
  logic             w_any_req;
  logic             w_own_req;
  logic             w_higher_req;
  logic [CNT_W-1:0] w_last;
  logic [3:0]       w_done_sel;

  tick_edge_detect u_tick (
    .clk        (clk),
    .reset      (reset),
    .Ctrl_clk   (Ctrl_clk),
    .tick_pulse (w_tick)
  );

  assign w_req_fill = start_fill & state;
  assign w_any_req  = w_req_fill | Aspersao | Gotejamento | Limpeza;

  // Per-phase view: own request, anything outranking it, and its tick limit.
  always_comb begin
    w_own_req    = 1'b0;
    w_higher_req = 1'b0;
    w_last       = '0;
    w_done_sel   = 4'b0000;
    case (r_phase)
      PH_FILL: begin
        w_own_req  = w_req_fill;
        w_last     = c_FILL_LAST;
        w_done_sel = 4'b0001;
      end
      PH_ASP: begin
        w_own_req    = Aspersao;
        w_higher_req = w_req_fill;
        w_last       = c_ASP_LAST;
        w_done_sel   = 4'b0010;
      end
      PH_GOT: begin
        w_own_req    = Gotejamento;
        w_higher_req = w_req_fill | Aspersao;
        w_last       = c_GOT_LAST;
        w_done_sel   = 4'b0100;
      end
      PH_LIMP: begin
        w_own_req    = Limpeza;
        w_higher_req = w_req_fill | Aspersao | Gotejamento;
        w_last       = c_LIMP_LAST;
        w_done_sel   = 4'b1000;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 4'b0000;
    if (ERRO) begin
      w_phase_nxt = PH_HALT;
      w_cnt_nxt   = '0;
    end else begin
      case (r_phase)
        PH_IDLE: begin
          w_cnt_nxt = '0;
          if (w_req_fill)       w_phase_nxt = PH_FILL;
          else if (Aspersao)    w_phase_nxt = PH_ASP;
          else if (Gotejamento) w_phase_nxt = PH_GOT;
          else if (Limpeza)     w_phase_nxt = PH_LIMP;
        end
        PH_FILL, PH_ASP, PH_GOT, PH_LIMP: begin
          // Abort outranks completion when both land in the same cycle.
          if (!w_own_req || w_higher_req) begin
            w_phase_nxt = PH_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt == w_last) begin
              w_phase_nxt = PH_WAIT;
              w_cnt_nxt   = '0;
              w_done_nxt  = w_done_sel;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        PH_WAIT, PH_HALT: begin
          if (!w_any_req) w_phase_nxt = PH_IDLE;
        end
        default: begin
          w_phase_nxt = PH_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_done  <= 4'b0000;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign fill_done  = r_done[0];
  assign asp_done   = r_done[1];
  assign got_done   = r_done[2];
  assign limp_done  = r_done[3];
  assign phase      = r_phase;
  assign tick_count = r_cnt;
  assign busy       = (r_phase == PH_FILL) || (r_phase == PH_ASP) ||
                      (r_phase == PH_GOT)  || (r_phase == PH_LIMP);
  assign err_halt   = (r_phase == PH_HALT);

endmodule

`default_nettype wire
